// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial sequential ALU: opcodes, flag bit
// positions and the host-side driver state encoding.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;

  // Bit positions within the ALU flag nibble.
  localparam int unsigned DONE  = 0;
  localparam int unsigned CARRY = 1;
  localparam int unsigned ZERO  = 2;
  localparam int unsigned SIGN  = 3;

  typedef enum logic [2:0] {
    StResync,
    StIdle,
    StSendOp1,
    StSendOp2,
    StSendOpc,
    StSendExec,
    StWaitDone,
    StResp
  } drv_state_e;

endpackage

// File: rtl/alu_seq_driver.sv
// Host-side initiator for the nibble-serial ALU: serialises one request, waits
// for done (or times out and resyncs the ALU) and returns the captured result.
module alu_seq_driver
  import alu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op1,
  input  logic [3:0] req_op2,
  input  logic [3:0] req_opcode,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic       rsp_timeout,
  output logic [3:0] alu_data,
  output logic       alu_enable,
  output logic       alu_rst,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic       busy
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  drv_state_e state_q, state_d;
  logic [3:0] op1_q, op1_d;
  logic [3:0] op2_q, op2_d;
  logic [3:0] opc_q, opc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] result_d;
  logic [2:0] flags_d;
  logic       timeout_d;
  logic [3:0] alu_data_d;

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    opc_d     = opc_q;
    cnt_d     = cnt_q;
    result_d  = rsp_result;
    flags_d   = rsp_flags;
    timeout_d = rsp_timeout;

    unique case (state_q)
      StResync:   state_d = StIdle;
      StIdle: begin
        if (req_valid) begin
          op1_d   = req_op1;
          op2_d   = req_op2;
          opc_d   = req_opcode;
          state_d = StSendOp1;
        end
      end
      StSendOp1:  state_d = StSendOp2;
      StSendOp2:  state_d = StSendOpc;
      StSendOpc:  state_d = StSendExec;
      StSendExec: begin
        cnt_d   = 8'd0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // A fresh done always wins over an expiring timeout in the same cycle.
        if (alu_flags[DONE]) begin
          result_d  = alu_result;
          flags_d   = alu_flags[SIGN:CARRY];
          timeout_d = 1'b0;
          state_d   = StResp;
        end else if (cnt_q == TimeoutLast) begin
          result_d  = 4'd0;
          flags_d   = 3'd0;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = rsp_timeout ? StResync : StIdle;
        end
      end
      default:    state_d = StResync;
    endcase

    case (state_d)
      StSendOp1: alu_data_d = op1_d;
      StSendOp2: alu_data_d = op2_q;
      StSendOpc: alu_data_d = opc_q;
      default:   alu_data_d = 4'd0;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StResync;
      op1_q       <= 4'd0;
      op2_q       <= 4'd0;
      opc_q       <= 4'd0;
      cnt_q       <= 8'd0;
      alu_rst     <= 1'b1;
      alu_enable  <= 1'b0;
      alu_data    <= 4'd0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 4'd0;
      rsp_flags   <= 3'd0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      opc_q       <= opc_d;
      cnt_q       <= cnt_d;
      alu_rst     <= (state_d == StResync);
      alu_enable  <= (state_d inside {StSendOp1, StSendOp2, StSendOpc, StSendExec});
      alu_data    <= alu_data_d;
      req_ready   <= (state_d == StIdle);
      rsp_valid   <= (state_d == StResp);
      rsp_result  <= result_d;
      rsp_flags   <= flags_d;
      rsp_timeout <= timeout_d;
      busy        <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_alu_seq_driver.sv
// Bench for alu_seq_driver: a behavioural nibble-serial ALU plus a response
// scoreboard fed with expected values at request time.
module tb_alu_seq_driver;
  import alu_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op1;
  logic [3:0] req_op2;
  logic [3:0] req_opcode;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       rsp_timeout;
  logic [3:0] alu_data;
  logic       alu_enable;
  logic       alu_rst;
  logic [3:0] alu_result;
  logic [3:0] alu_flags;
  logic       busy;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0] r;
    logic [2:0] f;
    logic       t;
  } exp_t;
  exp_t sb[$];

  alu_seq_driver #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_timeout(rsp_timeout),
    .alu_data   (alu_data),
    .alu_enable (alu_enable),
    .alu_rst    (alu_rst),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: op1, op2, opcode nibbles, then an execute nibble.
  logic [3:0] m_a, m_b, m_op, m_res;
  logic [2:0] m_flg;
  logic       m_done;
  logic [1:0] m_idx;
  logic       hang;

  assign alu_result = m_res;
  assign alu_flags  = {m_flg, m_done};

  function automatic logic [6:0] alu_calc(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op, input logic [3:0] prev);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    s = 5'd0;
    c = 1'b0;
    r = prev;
    case (op)
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_ROL:  r = {a[2:0], a[3]};
      OP_ROR:  r = {a[0], a[3:1]};
      OP_SWAP: r = {a[1:0], a[3:2]};
      OP_CMP:  r = (a == b) ? 4'd1 : 4'd0;
      default: ;
    endcase
    return {r[3], (r == 4'd0), c, r};
  endfunction

  always_ff @(posedge clk) begin
    if (alu_rst) begin
      m_a <= 4'd0; m_b <= 4'd0; m_op <= 4'd0; m_res <= 4'd0;
      m_flg <= 3'd0; m_done <= 1'b0; m_idx <= 2'd0;
    end else if (alu_enable) begin
      m_idx <= m_idx + 2'd1;
      case (m_idx)
        2'd0: begin m_a <= alu_data; m_done <= 1'b0; end
        2'd1: m_b <= alu_data;
        2'd2: m_op <= alu_data;
        default: begin
          if (!hang) begin
            {m_flg, m_res} <= alu_calc(m_a, m_b, m_op, m_res);
            m_done <= 1'b1;
          end
        end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accepts one request in the current IDLE cycle and follows it to rsp_valid.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o,
                      input logic [3:0] er, input logic [2:0] ef, input logic et,
                      input int lat, input string nm);
    logic [3:0] seq[4];
    int n;
    seq[0] = a; seq[1] = b; seq[2] = o; seq[3] = 4'd0;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s req_ready: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_op1 = a; req_op2 = b; req_opcode = o;
    sb.push_back('{r: er, f: ef, t: et});
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (alu_enable !== 1'b1 || alu_data !== seq[i]) begin
        failures++;
        $display("FAIL %s send cycle %0d: got en=%b data=%h want en=1 data=%h",
                 nm, i + 1, alu_enable, alu_data, seq[i]);
      end
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy cycle %0d: got ready=%b busy=%b want 0/1",
                 nm, i + 1, req_ready, busy);
      end
      cyc();
    end
    n = 5;
    while (rsp_valid !== 1'b1 && n < 200) begin
      checks++;
      if (alu_enable !== 1'b0) begin
        failures++; $display("FAIL %s wait enable c%0d: got %b want 0", nm, n, alu_enable);
      end
      cyc();
      n++;
    end
    checks++;
    if (n != lat) begin
      failures++; $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
    end
  endtask

  // Completes the response handshake in the current cycle and scores it.
  task automatic receive(input string nm);
    exp_t e;
    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL %s rsp_valid: got %b want 1", nm, rsp_valid);
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard: got empty want entry", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rsp_result !== e.r) begin
        failures++; $display("FAIL %s result: got %h want %h", nm, rsp_result, e.r);
      end
      checks++;
      if (rsp_flags !== e.f) begin
        failures++; $display("FAIL %s flags: got %b want %b", nm, rsp_flags, e.f);
      end
      checks++;
      if (rsp_timeout !== e.t) begin
        failures++; $display("FAIL %s timeout: got %b want %b", nm, rsp_timeout, e.t);
      end
    end
    cyc();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL %s rsp_valid after: got %b want 0", nm, rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({alu_rst, alu_enable, alu_data, req_ready, rsp_valid, busy} !== 9'b1_0_0000_0_0_1) begin
      failures++;
      $display("FAIL reset outputs: got rst=%b en=%b data=%h rdy=%b vld=%b busy=%b want 1 0 0 0 0 1",
               alu_rst, alu_enable, alu_data, req_ready, rsp_valid, busy);
    end
    checks++;
    if ({rsp_result, rsp_flags, rsp_timeout} !== 8'h00) begin
      failures++;
      $display("FAIL reset response: got %h %b %b want 0 000 0", rsp_result, rsp_flags, rsp_timeout);
    end
    reset = 1'b0;
    checks++;
    if (alu_rst !== 1'b1) begin
      failures++; $display("FAIL reset resync: got alu_rst=%b want 1", alu_rst);
    end
    cyc();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || alu_rst !== 1'b0) begin
      failures++;
      $display("FAIL reset idle: got rdy=%b busy=%b rst=%b want 1 0 0", req_ready, busy, alu_rst);
    end
  endtask

  task automatic test_add();
    send(4'd9, 4'd8, OP_ADD, 4'h1, 3'b001, 1'b0, 6, "add");
    receive("add");
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    send(4'd3, 4'd5, OP_SUB, 4'hE, 3'b100, 1'b0, 6, "sub1");
    receive("sub1");
    send(4'd7, 4'd7, OP_SUB, 4'h0, 3'b010, 1'b0, 6, "sub2");
    receive("sub2");
  endtask

  task automatic test_cmp_backpressure();
    send(4'd4, 4'd4, OP_CMP, 4'h1, 3'b000, 1'b0, 6, "cmp");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 4'h1 || rsp_flags !== 3'b000) begin
        failures++;
        $display("FAIL hold c%0d: got vld=%b res=%h flg=%b want 1 1 000",
                 i, rsp_valid, rsp_result, rsp_flags);
      end
      checks++;
      if (req_ready !== 1'b0 || alu_enable !== 1'b0) begin
        failures++;
        $display("FAIL hold quiet c%0d: got rdy=%b en=%b want 0 0", i, req_ready, alu_enable);
      end
      cyc();
    end
    receive("cmp");
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL cmp idle: got req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_timeout();
    hang = 1'b1;
    send(4'd2, 4'd3, OP_ADD, 4'h0, 3'b000, 1'b1, 13, "timeout");
    receive("timeout");
    checks++;
    if (alu_rst !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL timeout resync: got rst=%b rdy=%b want 1 0", alu_rst, req_ready);
    end
    cyc();
    checks++;
    if (alu_rst !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout idle: got rst=%b rdy=%b want 0 1", alu_rst, req_ready);
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    req_valid = 1'b1; req_op1 = 4'd6; req_op2 = 4'd2; req_opcode = OP_AND;
    cyc();
    req_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (alu_enable !== 1'b1 || alu_data !== OP_AND) begin
      failures++;
      $display("FAIL midop opc: got en=%b data=%h want 1 %h", alu_enable, alu_data, OP_AND);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (alu_enable !== 1'b0 || alu_rst !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL midop reset: got en=%b rst=%b vld=%b rdy=%b want 0 1 0 0",
               alu_enable, alu_rst, rsp_valid, req_ready);
    end
    cyc();
    checks++;
    if (req_ready !== 1'b1 || alu_rst !== 1'b0) begin
      failures++;
      $display("FAIL midop idle: got rdy=%b rst=%b want 1 0", req_ready, alu_rst);
    end
    send(4'd1, 4'd1, OP_ADD, 4'h2, 3'b000, 1'b0, 6, "fresh");
    receive("fresh");
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; hang = 1'b0;
    req_valid = 1'b0; req_op1 = 4'd0; req_op2 = 4'd0; req_opcode = 4'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_cmp_backpressure();
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
